// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the sync_fifo_flags block.
//   ptr_w(depth) : read/write pointer width for a given depth
//   lvl_w(depth) : occupancy counter width (must hold 0..depth inclusive)
//   ERR_*        : bit positions inside the sticky error register
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_W   = 2;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Handshake/status bundle between a producer/consumer (master) and the FIFO (slave).
//   master drives : write_en, data_in, read_en, clear_err
//   slave drives  : data_out, data_valid, full, empty, almost_full, almost_empty,
//                   level, overflow, underflow
interface sync_fifo_flags_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);
    localparam int LW = lvl_w(DEPTH);

    logic                  write_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_en;
    logic                  clear_err;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [LW-1:0]         level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_en, data_in, read_en, clear_err,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  write_en, data_in, read_en, clear_err,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_flags_ram.sv
// Storage array for sync_fifo_flags: simple dual-port, synchronous write,
// asynchronous read. Contents are never reset.
//   clock : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data (mem[raddr])
module fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int PW        = ptr_w(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [PW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy level, programmable almost-full/almost-empty
// flags, show-ahead or registered read port, and sticky overflow/underflow.
//   clock   : single clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : sync_fifo_flags_if slave (write/read requests, data, flags, level)
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit OUT_REG    = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    sync_fifo_flags_if.slave  bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    generate
        if (DATA_WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_geom
            $error("sync_fifo_flags: DATA_WIDTH must be >=1 and DEPTH a power of two >=2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("sync_fifo_flags: AF_THRESH out of range 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo_flags: AE_THRESH out of range 0..DEPTH-1");
        end
    endgenerate

    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level_q;
    logic [ERR_W-1:0]      err_q;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  empty, full;
    logic                  rd_acc, wr_acc;
    logic                  set_ovf, set_unf;

    // Flags decode straight from the registered level.
    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));

    // A read at empty is refused even if a write lands the same cycle; a write
    // at full is allowed when a read frees the slot in the same cycle.
    assign rd_acc  = bus.read_en & ~empty;
    assign wr_acc  = bus.write_en & (~full | rd_acc);
    assign set_ovf = bus.write_en & full & ~rd_acc;
    assign set_unf = bus.read_en & empty;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            if (wr_acc && !rd_acc)      level_q <= level_q + LW'(1);
            else if (rd_acc && !wr_acc) level_q <= level_q - LW'(1);
        end
    end

    // Sticky errors: a new set event beats a same-cycle clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_q <= '0;
        end else begin
            if (set_ovf)            err_q[ERR_OVF] <= 1'b1;
            else if (bus.clear_err) err_q[ERR_OVF] <= 1'b0;
            if (set_unf)            err_q[ERR_UNF] <= 1'b1;
            else if (bus.clear_err) err_q[ERR_UNF] <= 1'b0;
        end
    end

    generate
        if (OUT_REG) begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  dval_q;

            // Word captured at the popping edge; data_valid is a one-cycle strobe.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    dout_q <= '0;
                    dval_q <= 1'b0;
                end else begin
                    dval_q <= rd_acc;
                    if (rd_acc) dout_q <= rdata;
                end
            end

            assign bus.data_out   = dout_q;
            assign bus.data_valid = dval_q;
        end else begin : g_show_ahead
            // Gate with empty so stale/uninitialised storage never leaks out.
            assign bus.data_out   = empty ? '0 : rdata;
            assign bus.data_valid = ~empty;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level_q >= LW'(AF_THRESH));
    assign bus.almost_empty = (level_q <= LW'(AE_THRESH));
    assign bus.level        = level_q;
    assign bus.overflow     = err_q[ERR_OVF];
    assign bus.underflow    = err_q[ERR_UNF];

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one show-ahead and one registered-read instance
// driven in lockstep and compared against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    sync_fifo_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
    sync_fifo_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
                      .OUT_REG(1'b0))
        dut_sa (.clock(clock), .reset_n(reset_n), .bus(bus0));

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
                      .OUT_REG(1'b1))
        dut_rg (.clock(clock), .reset_n(reset_n), .bus(bus1));

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf;
    logic [DW-1:0] m_rd;
    bit            m_rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("sa.level",  32'(bus0.level),        32'(n));
        chk("sa.empty",  32'(bus0.empty),        32'(n == 0));
        chk("sa.full",   32'(bus0.full),         32'(n == DEPTH));
        chk("sa.afull",  32'(bus0.almost_full),  32'(n >= AF));
        chk("sa.aempty", 32'(bus0.almost_empty), 32'(n <= AE));
        chk("sa.ovf",    32'(bus0.overflow),     32'(m_ovf));
        chk("sa.unf",    32'(bus0.underflow),    32'(m_unf));
        chk("sa.dvalid", 32'(bus0.data_valid),   32'(n > 0));
        chk("sa.dout",   32'(bus0.data_out),     (n > 0) ? 32'(q[0]) : 32'd0);
        chk("rg.level",  32'(bus1.level),        32'(n));
        chk("rg.ovf",    32'(bus1.overflow),     32'(m_ovf));
        chk("rg.unf",    32'(bus1.underflow),    32'(m_unf));
        chk("rg.dvalid", 32'(bus1.data_valid),   32'(m_rv));
        chk("rg.dout",   32'(bus1.data_out),     32'(m_rd));
    endtask

    // One clock: drive at negedge, advance model at posedge, check 1 ns later.
    task automatic step(input bit rst_n, input bit we, input logic [DW-1:0] din,
                        input bit re, input bit clr);
        int n;
        bit rd_ok, wr_ok;
        @(negedge clock);
        reset_n        = rst_n;
        bus0.write_en  = we;  bus1.write_en  = we;
        bus0.data_in   = din; bus1.data_in   = din;
        bus0.read_en   = re;  bus1.read_en   = re;
        bus0.clear_err = clr; bus1.clear_err = clr;
        @(posedge clock);
        if (!rst_n) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_rd = '0; m_rv = 0;
        end else begin
            n     = q.size();
            rd_ok = re && (n > 0);
            wr_ok = we && ((n < DEPTH) || rd_ok);
            if (we && n == DEPTH && !rd_ok) m_ovf = 1; else if (clr) m_ovf = 0;
            if (re && n == 0)               m_unf = 1; else if (clr) m_unf = 0;
            if (rd_ok) begin
                m_rd = q.pop_front();
                m_rv = 1;
            end else begin
                m_rv = 0;
            end
            if (wr_ok) q.push_back(din);
        end
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus0.write_en = 0; bus0.read_en = 0; bus0.clear_err = 0; bus0.data_in = '0;
        bus1.write_en = 0; bus1.read_en = 0; bus1.clear_err = 0; bus1.data_in = '0;
        m_ovf = 0; m_unf = 0; m_rd = '0; m_rv = 0;

        // reset, with other inputs asserted to show reset dominates
        step(0, 1, 8'hFF, 1, 0);
        step(0, 0, 8'h00, 0, 0);

        // fill 0x01..0x10, then drain in order
        for (int i = 1; i <= DEPTH; i++) step(1, 1, DW'(i), 0, 0);
        for (int i = 0; i < DEPTH; i++)  step(1, 0, 8'h00, 1, 0);

        // full pass-through: 0xAA accepted while popping, level stays full
        for (int i = 1; i <= DEPTH; i++) step(1, 1, DW'(i), 0, 0);
        step(1, 1, 8'hAA, 1, 0);
        for (int i = 0; i < DEPTH; i++)  step(1, 0, 8'h00, 1, 0);
        chk("passthru.last", 32'(m_rd), 32'h0000_00AA);

        // empty simultaneous: read refused (underflow), write lands
        step(1, 1, 8'h55, 1, 0);
        step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 0, 1);

        // overflow, clear, then clear colliding with a new overflow
        for (int i = 0; i < DEPTH; i++) step(1, 1, DW'(8'h30 + i), 0, 0);
        step(1, 1, 8'h77, 0, 0);
        step(1, 0, 8'h00, 0, 1);
        step(1, 1, 8'h88, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 0, 1);

        // random interleaved traffic with stalls
        for (int i = 0; i < 40; i++)
            step(1, 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < 60; i++)
            step(1, 1'($urandom_range(0, 3) != 0), DW'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));

        // mid-stream reset at level 7
        while (q.size() > 7) step(1, 0, 8'h00, 1, 0);
        while (q.size() < 7) step(1, 1, DW'($urandom), 0, 0);
        step(0, 1, 8'hEE, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, DW'($urandom), 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 8'h00, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
